// File: rtl/nrisc_ula_pkg.sv
// Shared definitions for the NRISC_ULA ALU and its request sequencer.
// ALU command encoding is {rotate, op[2:0]}; only SHR/SHL honour the rotate bit.
package nrisc_ula_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHR  = 3'b101;
    localparam logic [2:0] OP_SHL  = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;
    localparam logic       CMD_ROT = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_CAPT = 2'b10,
        ST_DONE = 2'b11
    } seq_state_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op[2:0] == OP_SHR) || (op[2:0] == OP_SHL);
    endfunction

endpackage

// File: rtl/nrisc_ula_seq.sv
// ALU request sequencer: single-pass ops take 3 cycles, shift by n loops the 1-bit ALU shift (1+2n cycles).
// Accepts only in IDLE; the result is held in DONE until resp_ready, with no same-cycle turnaround.
module nrisc_ula_seq
    import nrisc_ula_pkg::*;
#(
    parameter int TAM   = 16,
    parameter int CNT_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [3:0]     req_op,
    input  logic [TAM-1:0] req_a,
    input  logic [TAM-1:0] req_b,
    output logic           resp_valid,
    input  logic           resp_ready,
    output logic [TAM-1:0] resp_data,
    output logic [2:0]     resp_flags,
    output logic [TAM-1:0] ULA_A,
    output logic [TAM-1:0] ULA_B,
    output logic [3:0]     ULA_ctrl,
    input  logic [TAM-1:0] ULA_OUT,
    input  logic [2:0]     ULA_flags
);

    seq_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAM-1:0] ula_a_q, ula_a_d;
    logic [TAM-1:0] ula_b_q, ula_b_d;
    logic [3:0]     ula_ctrl_q, ula_ctrl_d;
    logic [TAM-1:0] resp_data_q, resp_data_d;
    logic [2:0]     resp_flags_q, resp_flags_d;

    logic             req_shift;
    logic [CNT_W-1:0] req_cnt;
    logic [CNT_W-1:0] cnt_dec;

    assign req_shift = is_shift_op(req_op);
    assign req_cnt   = req_b[CNT_W-1:0];
    assign cnt_dec   = cnt_q - CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_ctrl_q   <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ula_a_q      <= ula_a_d;
            ula_b_q      <= ula_b_d;
            ula_ctrl_q   <= ula_ctrl_d;
            resp_data_q  <= resp_data_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ula_a_d      = ula_a_q;
        ula_b_d      = ula_b_q;
        ula_ctrl_d   = ula_ctrl_q;
        resp_data_d  = resp_data_q;
        resp_flags_d = resp_flags_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d = req_shift ? req_cnt : CNT_W'(1);
                    if (req_shift && (req_cnt == '0)) begin
                        // Zero-count shift never touches the ALU: the operand is the answer.
                        state_d      = ST_DONE;
                        resp_data_d  = req_a;
                        resp_flags_d = {1'b0, (req_a == '0), 1'b0};
                    end else begin
                        state_d    = ST_EXEC;
                        ula_a_d    = req_a;
                        ula_b_d    = req_shift ? '0 : req_b;
                        ula_ctrl_d = req_op;
                    end
                end
            end
            ST_EXEC: begin
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                resp_data_d  = ULA_OUT;
                resp_flags_d = ULA_flags;
                cnt_d        = cnt_dec;
                if (cnt_dec != '0) begin
                    state_d = ST_EXEC;
                    ula_a_d = ULA_OUT;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready) begin
                    state_d    = ST_IDLE;
                    ula_ctrl_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = resp_data_q;
    assign resp_flags = resp_flags_q;
    assign ULA_A      = ula_a_q;
    assign ULA_B      = ula_b_q;
    assign ULA_ctrl   = ula_ctrl_q;

endmodule

// File: tb/tb_nrisc_ula_seq.sv
// Bench for the ALU sequencer with a registered 1-cycle ALU model attached to the ULA_* port.
module tb_nrisc_ula_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  req_op = '0;
    logic [15:0] req_a = '0;
    logic [15:0] req_b = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [15:0] resp_data;
    logic [2:0]  resp_flags;
    logic [15:0] ula_a_w, ula_b_w;
    logic [3:0]  ula_ctrl_w;
    logic [15:0] ula_out = '0;
    logic [2:0]  ula_flags = '0;

    nrisc_ula_seq #(.TAM(16), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_flags (resp_flags),
        .ULA_A      (ula_a_w),
        .ULA_B      (ula_b_w),
        .ULA_ctrl   (ula_ctrl_w),
        .ULA_OUT    (ula_out),
        .ULA_flags  (ula_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-step ALU: shifts move a single bit; carry is the bit shifted out or the add carry / sub borrow.
    function automatic logic [18:0] alu_step(input logic [3:0] ctrl, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        s = '0;
        c = 1'b0;
        case (ctrl[2:0])
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            3'b001: begin r = a - b; c = (a < b); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: begin r = {(ctrl[3] ? a[0] : 1'b0), a[15:1]}; c = a[0]; end
            3'b110: begin r = {a[14:0], (ctrl[3] ? a[15] : 1'b0)}; c = a[15]; end
            default: r = ~a;
        endcase
        return {r[15], (r == 16'h0), c, r};
    endfunction

    always @(posedge clk) {ula_flags, ula_out} <= alu_step(ula_ctrl_w, ula_a_w, ula_b_w);

    typedef struct {
        logic [15:0] data;
        logic [2:0]  flags;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    // Whole-operation reference: n-bit shifts and rotates computed in one step.
    function automatic exp_t ref_model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        exp_t        e;
        int          n;
        logic [31:0] aw;
        logic [16:0] s;
        logic [15:0] r;
        logic        c;
        n  = int'(b[3:0]);
        aw = {16'h0, a};
        c  = 1'b0;
        e.lat = 3;
        e.acc = 0;
        if ((op[2:0] == 3'b101 || op[2:0] == 3'b110) && n == 0) begin
            e.data  = a;
            e.flags = {1'b0, (a == 16'h0), 1'b0};
            e.lat   = 1;
            return e;
        end
        case (op[2:0])
            3'b000: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16]; end
            3'b001: begin r = a - b; c = (a < b); end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b100: r = a ^ b;
            3'b101: begin
                r = 16'(aw >> n) | (op[3] ? 16'(aw << (16 - n)) : 16'h0);
                c = a[n-1];
                e.lat = 1 + 2 * n;
            end
            3'b110: begin
                r = 16'(aw << n) | (op[3] ? 16'(aw >> (16 - n)) : 16'h0);
                c = a[16-n];
                e.lat = 1 + 2 * n;
            end
            default: r = ~a;
        endcase
        e.data  = r;
        e.flags = {r[15], (r == 16'h0), c};
        return e;
    endfunction

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: pop on the first DONE cycle of each response, then require it stable until handshake.
    bit          seen = 1'b0;
    logic [15:0] held_d;
    logic [2:0]  held_f;
    exp_t        m_e;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (resp_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    check("unexpected_resp", 32'(resp_data), 32'hFFFF_FFFF);
                end else begin
                    m_e = sb.pop_front();
                    check("resp_data", 32'(resp_data), 32'(m_e.data));
                    check("resp_flags", 32'(resp_flags), 32'(m_e.flags));
                    check("resp_latency", 32'(cyc - m_e.acc + 1), 32'(m_e.lat));
                end
                seen   = 1'b1;
                held_d = resp_data;
                held_f = resp_flags;
            end else begin
                check("hold_data", 32'(resp_data), 32'(held_d));
                check("hold_flags", 32'(resp_flags), 32'(held_f));
            end
            check("no_accept_in_done", 32'(req_ready), 32'd0);
            if (resp_ready) seen = 1'b0;
        end
    end

    bit   rr_rand = 1'b1;
    logic rr_val  = 1'b1;
    always @(posedge clk) begin
        #2;
        resp_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_val;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input bit push);
        int   w;
        exp_t e;
        w = 0;
        while (!req_ready && w < 500) begin
            tick(1);
            w++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            return;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        e     = ref_model(op, a, b);
        e.acc = cyc + 1;
        if (push) sb.push_back(e);
        tick(1);
        req_valid = 1'b0;
        req_op    = 4'($urandom);
        req_a     = 16'($urandom);
        req_b     = 16'($urandom);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb.size() != 0 || !req_ready) && w < 1000) begin
            tick(1);
            w++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int w;
        rst = 1'b1;
        tick(3);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_resp_flags", 32'(resp_flags), 32'd0);
        check("rst_ula_a", 32'(ula_a_w), 32'd0);
        check("rst_ula_b", 32'(ula_b_w), 32'd0);
        check("rst_ula_ctrl", 32'(ula_ctrl_w), 32'd0);
        rst = 1'b0;
        tick(1);

        // ADD: operands and command presented in EXEC.
        issue(4'b0000, 16'h0005, 16'h0003, 1'b1);
        check("add_exec_ctrl", 32'(ula_ctrl_w), 32'h0);
        check("add_exec_a", 32'(ula_a_w), 32'h5);
        check("add_exec_b", 32'(ula_b_w), 32'h3);
        wait_idle();

        // Rotate left by 4: B forced to zero while iterating.
        issue(4'b1110, 16'h8001, 16'h0004, 1'b1);
        check("rotl_exec_ctrl", 32'(ula_ctrl_w), 32'hE);
        check("rotl_exec_b", 32'(ula_b_w), 32'h0);
        wait_idle();

        // Shift by 0 completes without driving the ALU.
        issue(4'b0101, 16'h1234, 16'h0000, 1'b1);
        check("shift0_ctrl_idle", 32'(ula_ctrl_w), 32'h0);
        check("shift0_done", 32'(resp_valid), 32'd1);
        wait_idle();

        // Count taken from the low bits of B only.
        issue(4'b0110, 16'h0001, 16'h0011, 1'b1);
        wait_idle();

        // Backpressure in DONE with a competing request.
        rr_val  = 1'b0;
        rr_rand = 1'b0;
        tick(1);
        issue(4'b0000, 16'h7FFF, 16'h0001, 1'b1);
        w = 0;
        while (!resp_valid && w < 50) begin
            tick(1);
            w++;
        end
        check("bp_reached_done", 32'(resp_valid), 32'd1);
        req_valid = 1'b1;
        req_op    = 4'b0011;
        req_a     = 16'hAAAA;
        req_b     = 16'h5555;
        repeat (5) begin
            tick(1);
            check("bp_resp_valid", 32'(resp_valid), 32'd1);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rr_val    = 1'b1;
        tick(1);
        check("bp_release_idle", 32'(req_ready), 32'd1);
        check("bp_release_valid", 32'(resp_valid), 32'd0);
        rr_rand = 1'b1;

        // Reset during the third CAPT of a rotate by 8 drops the operation.
        issue(4'b1101, 16'hC3A5, 16'h0008, 1'b0);
        tick(5);
        rst = 1'b1;
        tick(1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_ula_ctrl", 32'(ula_ctrl_w), 32'd0);
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        tick(1);
        issue(4'b0000, 16'h1111, 16'h2222, 1'b1);
        wait_idle();

        // Randomized traffic with random consumer stalls.
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom), 16'($urandom), 16'($urandom), 1'b1);
            tick($urandom_range(0, 2));
        end
        wait_idle();
        tick(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
